// File: rtl/matmul_stream_core.sv
// matmul_stream_core: streams in a size word, then matrices A and B, computes
// C = A x B with a two-stage multiply/accumulate pipeline, and streams every
// result element out as OUT_BYTES little-endian bytes over valid/ready.
module matmul_stream_core #(
    parameter int DATA_W    = 8,
    parameter int MAX_SIZE  = 10,
    parameter int ACC_W     = 24,
    parameter int OUT_BYTES = 3,
    parameter int SIGNED    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int   CELLS  = MAX_SIZE * MAX_SIZE;
    localparam int   ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int   PROD_W = 2 * DATA_W;
    localparam int   OUT_W  = 8 * OUT_BYTES;
    localparam logic SGN    = (SIGNED != 0);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        SEND
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem_a [CELLS];
    logic [DATA_W-1:0] mem_b [CELLS];

    logic [7:0]        n_q;
    logic [7:0]        ci;
    logic [7:0]        cj;
    logic [7:0]        cc;
    logic [7:0]        byte_cnt;
    logic [ADDR_W-1:0] idx;

    logic              v1;
    logic              first1;
    logic [ACC_W-1:0]  p1;
    logic [ACC_W-1:0]  acc;
    logic [OUT_W-1:0]  shreg;
    logic              err_q;
    logic              done_q;

    logic              in_fire;
    logic              out_fire;
    logic [7:0]        size_word;
    logic              size_ok;
    logic [ADDR_W-1:0] nn_last;
    logic              load_last;
    logic              issue;
    logic              cell_end;
    logic              byte_last;
    logic              last_cell;
    logic [7:0]        k;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod_raw;
    logic [ACC_W-1:0]  prod_ext;
    logic [OUT_W-1:0]  res_ext;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign size_word = 8'(in_data);
    assign size_ok   = (size_word != 8'd0) && (32'(size_word) <= 32'(MAX_SIZE));
    assign nn_last   = ADDR_W'(n_q) * ADDR_W'(n_q) - ADDR_W'(1);
    assign load_last = (idx == nn_last);
    assign issue     = (state == COMPUTE) && (cc < n_q);
    assign cell_end  = (state == COMPUTE) && (cc == n_q + 8'd1);
    assign byte_last = (byte_cnt == 8'(OUT_BYTES - 1));
    assign last_cell = (ci == n_q - 8'd1) && (cj == n_q - 8'd1);
    assign k         = issue ? cc : 8'd0;
    assign a_addr    = ADDR_W'(ci) * ADDR_W'(n_q) + ADDR_W'(k);
    assign b_addr    = ADDR_W'(k) * ADDR_W'(n_q) + ADDR_W'(cj);

    // Operand/product extension: the product is formed at 2*DATA_W, then widened to ACC_W and the result to OUT_W
    always_comb begin
        a_ext                = {PROD_W{SGN & mem_a[a_addr][DATA_W-1]}};
        a_ext[DATA_W-1:0]    = mem_a[a_addr];
        b_ext                = {PROD_W{SGN & mem_b[b_addr][DATA_W-1]}};
        b_ext[DATA_W-1:0]    = mem_b[b_addr];
        prod_raw             = a_ext * b_ext;
        prod_ext             = {ACC_W{SGN & prod_raw[PROD_W-1]}};
        prod_ext[PROD_W-1:0] = prod_raw;
        res_ext              = {OUT_W{SGN & acc[ACC_W-1]}};
        res_ext[ACC_W-1:0]   = acc;
    end

    // Next-state logic for the load / compute / send sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire && size_ok) state_nxt = LOAD_A;
            LOAD_A:  if (in_fire && load_last) state_nxt = LOAD_B;
            LOAD_B:  if (in_fire && load_last) state_nxt = COMPUTE;
            COMPUTE: if (cell_end) state_nxt = SEND;
            SEND:    if (out_fire && byte_last) state_nxt = last_cell ? IDLE : COMPUTE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
        out_valid = (state == SEND);
        out_data  = (state == SEND) ? shreg[7:0] : 8'h00;
        busy      = (state != IDLE);
        done      = done_q;
        err       = err_q;
    end

    // State register; reset aborts any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Matrix storage is plain RAM, written only while loading
    always_ff @(posedge clk) begin
        if (in_fire && (state == LOAD_A)) mem_a[idx] <= in_data;
        if (in_fire && (state == LOAD_B)) mem_b[idx] <= in_data;
    end

    // Counters, MAC pipeline, output shifter and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= 8'd0;
            ci       <= 8'd0;
            cj       <= 8'd0;
            cc       <= 8'd0;
            byte_cnt <= 8'd0;
            idx      <= '0;
            v1       <= 1'b0;
            first1   <= 1'b0;
            p1       <= '0;
            acc      <= '0;
            shreg    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            v1     <= issue;
            first1 <= issue && (cc == 8'd0);
            if (issue) p1 <= prod_ext;
            if (v1) acc <= first1 ? p1 : acc + p1;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (size_ok) begin
                            n_q <= size_word;
                            idx <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (in_fire) begin
                        idx <= load_last ? '0 : idx + ADDR_W'(1);
                        if ((state == LOAD_B) && load_last) begin
                            ci <= 8'd0;
                            cj <= 8'd0;
                            cc <= 8'd0;
                        end
                    end
                end
                COMPUTE: begin
                    if (cell_end) begin
                        cc       <= 8'd0;
                        shreg    <= res_ext;
                        byte_cnt <= 8'd0;
                    end else begin
                        cc <= cc + 8'd1;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        shreg <= shreg >> 8;
                        if (byte_last) begin
                            byte_cnt <= 8'd0;
                            if (last_cell) begin
                                ci     <= 8'd0;
                                cj     <= 8'd0;
                                done_q <= 1'b1;
                            end else if (cj == n_q - 8'd1) begin
                                cj <= 8'd0;
                                ci <= ci + 8'd1;
                            end else begin
                                cj <= cj + 8'd1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
